// File: rtl/cordic_vector_pipe.sv
// cordic_vector_pipe
// Full-circle, fully pipelined CORDIC vectoring unit for the Sobel edge path.
// Converts a signed gradient pair (x, y) into a magnitude and a binary-angle
// phase (2^ZW per full circle). Frame/line syncs travel with matched latency.
//
// Pipeline: pre-fold stage, T_IR_NUM vectoring stages, unfold/output stage.
// Optional compile-time feature, macro CORDIC_GAIN_COMP_EN: one extra stage
// that scales the magnitude by K ~= 0.607253 with a truncated shift-add. The
// angle and sync paths get a matching extra delay.
module cordic_vector_pipe #(
   parameter int DW       = 16,
   parameter int DW_DOT   = 4,
   parameter int T_IR_NUM = 15,
   parameter int ZW       = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 din_vsync,
   input  logic                 din_hsync,
   input  logic [DW-1:0]        din_x,
   input  logic [DW-1:0]        din_y,
   output logic                 dout_vsync,
   output logic                 dout_hsync,
   output logic [DW+DW_DOT:0]   dout_mag,
   output logic [ZW-1:0]        dout_ang
);

   localparam int W  = DW + DW_DOT + 2;
   localparam int MW = DW + DW_DOT + 1;

   localparam logic signed [ZW:0] Z_QTR    = $signed({3'b001, {(ZW-2){1'b0}}});
   localparam logic [ZW-1:0]      ANG_HALF = {1'b1, {(ZW-1){1'b0}}};

   // atan(2^-i) on a 2^32 full circle; rescaled with rounding to ZW by atan_step
   function automatic logic [31:0] atan32(input int i);
      logic [31:0] a;
      case (i)
         0:       a = 32'd536870912;
         1:       a = 32'd316933406;
         2:       a = 32'd167458907;
         3:       a = 32'd85004756;
         4:       a = 32'd42667331;
         5:       a = 32'd21354465;
         6:       a = 32'd10679838;
         7:       a = 32'd5340245;
         8:       a = 32'd2670163;
         9:       a = 32'd1335087;
         10:      a = 32'd667544;
         11:      a = 32'd333772;
         12:      a = 32'd166886;
         13:      a = 32'd83443;
         14:      a = 32'd41722;
         15:      a = 32'd20861;
         16:      a = 32'd10430;
         17:      a = 32'd5215;
         default: a = 32'd0;
      endcase
      return a;
   endfunction

   function automatic logic signed [ZW:0] atan_step(input int i);
      logic [32:0] r;
      r = {1'b0, atan32(i)} + (33'd1 << (31 - ZW));
      r = r >> (32 - ZW);
      return $signed(r[ZW:0]);
   endfunction

   // |v| with the most negative code saturated so it stays representable
   function automatic logic [DW-1:0] sat_abs(input logic [DW-1:0] v);
      logic [DW-1:0] m;
      m = v[DW-1] ? (0 - v) : v;
      if (m[DW-1]) m = {1'b0, {(DW-1){1'b1}}};
      return m;
   endfunction

   // index 0 is the pre-fold output, index i+1 the output of vectoring stage i
   logic signed [W-1:0] px [0:T_IR_NUM];
   logic signed [W-1:0] py [0:T_IR_NUM];
   logic signed [ZW:0]  pz [0:T_IR_NUM];
   logic [T_IR_NUM:0]   psx;
   logic [T_IR_NUM:0]   psy;
   logic [T_IR_NUM:0]   phs;
   logic [T_IR_NUM:0]   pvs;

   // pre-fold into the first quadrant, then the vectoring iterations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= T_IR_NUM; i++) begin
            px[i] <= '0;
            py[i] <= '0;
            pz[i] <= '0;
         end
         psx <= '0;
         psy <= '0;
         phs <= '0;
         pvs <= '0;
      end else begin
         px[0]  <= $signed({2'b00, sat_abs(din_x), {DW_DOT{1'b0}}});
         py[0]  <= $signed({2'b00, sat_abs(din_y), {DW_DOT{1'b0}}});
         pz[0]  <= '0;
         psx[0] <= din_x[DW-1];
         psy[0] <= din_y[DW-1];
         phs[0] <= din_hsync;
         pvs[0] <= din_vsync;
         for (int i = 0; i < T_IR_NUM; i++) begin
            if (!py[i][W-1]) begin
               px[i+1] <= px[i] + (py[i] >>> i);
               py[i+1] <= py[i] - (px[i] >>> i);
               pz[i+1] <= pz[i] + atan_step(i);
            end else begin
               px[i+1] <= px[i] - (py[i] >>> i);
               py[i+1] <= py[i] + (px[i] >>> i);
               pz[i+1] <= pz[i] - atan_step(i);
            end
            psx[i+1] <= psx[i];
            psy[i+1] <= psy[i];
            phs[i+1] <= phs[i];
            pvs[i+1] <= pvs[i];
         end
      end
   end

   logic [ZW-1:0] theta;
   logic [ZW-1:0] ang_unf;

   // clamp the residual angle to one quadrant, then unfold with the saved signs
   always_comb begin
      theta = '0;
      if (pz[T_IR_NUM] > Z_QTR)
         theta = Z_QTR[ZW-1:0];
      else if (!pz[T_IR_NUM][ZW])
         theta = pz[T_IR_NUM][ZW-1:0];
      case ({psx[T_IR_NUM], psy[T_IR_NUM]})
         2'b00:   ang_unf = theta;
         2'b10:   ang_unf = ANG_HALF - theta;
         2'b11:   ang_unf = ANG_HALF + theta;
         default: ang_unf = '0 - theta;
      endcase
      // x only grows through the iterations, so a zero final x means a zero input
      if (px[T_IR_NUM] == '0) ang_unf = '0;
   end

   logic          q_vs;
   logic          q_hs;
   logic [MW-1:0] q_mag;
   logic [ZW-1:0] q_ang;

   // output stage: data is blanked whenever the line is not valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_vs  <= 1'b0;
         q_hs  <= 1'b0;
         q_mag <= '0;
         q_ang <= '0;
      end else begin
         q_vs  <= pvs[T_IR_NUM];
         q_hs  <= phs[T_IR_NUM];
         q_mag <= phs[T_IR_NUM] ? px[T_IR_NUM][MW-1:0] : '0;
         q_ang <= phs[T_IR_NUM] ? ang_unf : '0;
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   logic [MW-1:0] mag_k;

   // K ~= 0.607253; the positive terms always dominate, so no underflow
   always_comb begin
      mag_k = (q_mag >> 1) + (q_mag >> 3) - (q_mag >> 6) - (q_mag >> 9)
            - (q_mag >> 12) + (q_mag >> 14);
   end

   // compensation stage with matching delay on angle and syncs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_vsync <= 1'b0;
         dout_hsync <= 1'b0;
         dout_mag   <= '0;
         dout_ang   <= '0;
      end else begin
         dout_vsync <= q_vs;
         dout_hsync <= q_hs;
         dout_mag   <= q_hs ? mag_k : '0;
         dout_ang   <= q_hs ? q_ang : '0;
      end
   end
`else
   // uncompensated: the output stage drives the ports directly
   always_comb begin
      dout_vsync = q_vs;
      dout_hsync = q_hs;
      dout_mag   = q_mag;
      dout_ang   = q_ang;
   end
`endif

endmodule

// File: tb/tb_cordic_vector_pipe.sv
// Testbench for cordic_vector_pipe: directed quadrant/boundary cases,
// randomized streams and a mid-stream reset, checked cycle by cycle
// against a reference model whose angle table comes from $atan.
module tb_cordic_vector_pipe;

   localparam int DW       = 16;
   localparam int DW_DOT   = 4;
   localparam int T_IR_NUM = 15;
   localparam int ZW       = 20;
   localparam int MW       = DW + DW_DOT + 1;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT      = T_IR_NUM + 3;
`else
   localparam int LAT      = T_IR_NUM + 2;
`endif
   localparam int ANG_TOL  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          din_vsync = 1'b0;
   logic          din_hsync = 1'b0;
   logic [DW-1:0] din_x = '0;
   logic [DW-1:0] din_y = '0;
   logic          dout_vsync;
   logic          dout_hsync;
   logic [MW-1:0] dout_mag;
   logic [ZW-1:0] dout_ang;

   cordic_vector_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_vsync  (din_vsync),
      .din_hsync  (din_hsync),
      .din_x      (din_x),
      .din_y      (din_y),
      .dout_vsync (dout_vsync),
      .dout_hsync (dout_hsync),
      .dout_mag   (dout_mag),
      .dout_ang   (dout_ang)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vs;
      logic hs;
      int   mag;
      int   ang;
   } exp_t;

   exp_t exp_q[$];
   int   atan_tab [T_IR_NUM];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_val(input string tag, input int obs, input int exp,
                            input int tol, input int wrap);
      int d;
      n_checks++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (wrap > 0 && d > wrap / 2) d = wrap - d;
      if (d > tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
      end
   endtask

   // magnitude and phase of (xi, yi) following the vectoring rules
   function automatic void ref_model(input int xi, input int yi, output int mag, output int ang);
      int lim, x, y, z, xn, th, m;
      bit neg_x, neg_y;
      lim   = (1 << (DW - 1)) - 1;
      neg_x = (xi < 0);
      neg_y = (yi < 0);
      x = neg_x ? -xi : xi;
      y = neg_y ? -yi : yi;
      if (x > lim) x = lim;
      if (y > lim) y = lim;
      x = x * (1 << DW_DOT);
      y = y * (1 << DW_DOT);
      z = 0;
      for (int i = 0; i < T_IR_NUM; i++) begin
         if (y >= 0) begin
            xn = x + (y >>> i);
            y  = y - (x >>> i);
            z  = z + atan_tab[i];
         end else begin
            xn = x - (y >>> i);
            y  = y + (x >>> i);
            z  = z - atan_tab[i];
         end
         x = xn;
      end
      th = (z < 0) ? 0 : ((z > (1 << (ZW - 2))) ? (1 << (ZW - 2)) : z);
      if (x == 0)
         ang = 0;
      else if (!neg_x && !neg_y)
         ang = th;
      else if (neg_x && !neg_y)
         ang = (1 << (ZW - 1)) - th;
      else if (neg_x && neg_y)
         ang = (1 << (ZW - 1)) + th;
      else
         ang = ((1 << ZW) - th) % (1 << ZW);
      m = x & ((1 << MW) - 1);
`ifdef CORDIC_GAIN_COMP_EN
      m = (m >> 1) + (m >> 3) - (m >> 6) - (m >> 9) - (m >> 12) + (m >> 14);
`endif
      mag = m;
   endfunction

   // drive one input cycle, then compare the output that is due this cycle
   task automatic step(input logic vs, input logic hs, input int xi, input int yi);
      exp_t e;
      int   m, a;
      @(posedge clk);
      #1;
      din_vsync = vs;
      din_hsync = hs;
      din_x     = DW'(xi);
      din_y     = DW'(yi);
      ref_model(xi, yi, m, a);
      e.vs  = vs;
      e.hs  = hs;
      e.mag = hs ? m : 0;
      e.ang = hs ? a : 0;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() > LAT) begin
         e = exp_q.pop_front();
         check_val("vsync", int'(dout_vsync), int'(e.vs), 0, 0);
         check_val("hsync", int'(dout_hsync), int'(e.hs), 0, 0);
         check_val("mag", int'(dout_mag), e.mag, 0, 0);
         check_val("ang", int'(dout_ang), e.ang, ANG_TOL, 1 << ZW);
      end
   endtask

   // the freshly reset pipeline holds LAT cycles of blank data
   task automatic restart_queue();
      exp_t z;
      z.vs  = 1'b0;
      z.hs  = 1'b0;
      z.mag = 0;
      z.ang = 0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back(z);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_vsync"}, int'(dout_vsync), 0, 0, 0);
      check_val({tag, "_hsync"}, int'(dout_hsync), 0, 0, 0);
      check_val({tag, "_mag"}, int'(dout_mag), 0, 0, 0);
      check_val({tag, "_ang"}, int'(dout_ang), 0, 0, 0);
   endtask

   initial begin
      int xr, yr;
      logic vs_r, hs_r;

      for (int i = 0; i < T_IR_NUM; i++)
         atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * (2.0 ** ZW) / (2.0 * 3.14159265358979) + 0.5);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      restart_queue();

      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);

      // single-cycle hsync pulses, one per quadrant and axis/boundary case
      step(1, 1, 112, 16);
      repeat (3) step(1, 0, 0, 0);
      step(1, 1, -112, 16);
      repeat (2) step(1, 0, 0, 0);
      step(1, 1, -112, -16);
      step(1, 0, 0, 0);
      step(1, 1, 112, -16);
      step(1, 0, 0, 0);
      step(1, 1, 0, -100);
      step(1, 0, 0, 0);
      step(1, 1, -32768, 0);
      step(1, 1, 32767, 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 100);
      step(1, 1, -100, 0);
      step(1, 1, -32768, -32768);
      step(1, 0, 0, 0);

      // five back-to-back samples within one frame
      step(1, 1, 1000, 2000);
      step(1, 1, -3000, 500);
      step(1, 1, -700, -7000);
      step(1, 1, 25000, -12000);
      step(1, 1, 5, 3);
      repeat (LAT + 2) step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      // randomized stream with sparse and dense hsync
      vs_r = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 63) == 0) vs_r = ~vs_r;
         hs_r = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            xr = int'($urandom_range(0, 255)) - 128;
            yr = int'($urandom_range(0, 255)) - 128;
         end else begin
            xr = int'($urandom_range(0, 65535)) - 32768;
            yr = int'($urandom_range(0, 65535)) - 32768;
         end
         step(vs_r, hs_r, xr, yr);
      end
      repeat (LAT + 2) step(0, 0, 0, 0);

      // mid-stream reset: valid data on the outputs and more in flight
      for (int n = 0; n < LAT + 3; n++)
         step(1, 1, 4000 + 37 * n, -9000 + 113 * n);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      din_vsync = 1'b0;
      din_hsync = 1'b0;
      din_x     = '0;
      din_y     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("in_rst");
      rst_n = 1'b1;
      restart_queue();
      repeat (LAT + 4) step(0, 0, 0, 0);
      step(1, 1, -20000, 15000);
      step(1, 1, 300, -30000);
      repeat (LAT + 2) step(1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cordic_vector_pipe.md
# cordic_vector_pipe

Full-circle, fully pipelined CORDIC vectoring unit for the Sobel edge-detect video path. It converts signed gradient pairs (x = Gx, y = Gy) into a magnitude and a binary-angle phase, so the input no longer has to be pre-folded into the 0°–45° octant. Frame and line syncs travel alongside the data with matched latency. Gain compensation of the magnitude is optional at compile time. The block sits directly after the Sobel convolution stage and feeds threshold and non-maximum suppression.

## Interface
- DW, 16: signed input x/y width, two's complement.
- DW_DOT, 4: fractional bits appended to x/y internally. Requires DW+DW_DOT+2 <= 32.
- T_IR_NUM, 15: number of iteration stages. Legal range 8..18, and it must satisfy T_IR_NUM <= ZW-2.
- ZW, 20: angle width. One full circle is 2^ZW.

Ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- din_vsync, in, 1: input frame-valid.
- din_hsync, in, 1: input line-valid; qualifies din_x and din_y.
- din_x, in, DW: signed x.
- din_y, in, DW: signed y.
- dout_vsync, out, 1: din_vsync delayed by LAT.
- dout_hsync, out, 1: din_hsync delayed by LAT.
- dout_mag, out, DW+1+DW_DOT: unsigned magnitude with DW_DOT fractional bits.
- dout_ang, out, ZW: unsigned phase, 0 .. 2^ZW-1, measured counter-clockwise from +x.

## Operation
- Stage P (pre-fold):
  - Register ax = |x| and ay = |y|, each extended by DW_DOT zero LSBs.
  - Register the quadrant flags sx = (x<0) and sy = (y<0).
  - If |x| or |y| equals -2^(DW-1), saturate it to 2^(DW-1)-1 before extension.
- Stages 0..T_IR_NUM-1 (vectoring), with internal signed width W = DW+DW_DOT+2:
  - If y >= 0: x' = x + (y>>>i), y' = y - (x>>>i), z' = z + A[i].
  - Otherwise: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - A[i].
  - Shifts are arithmetic. z starts at 0 and is ZW+1 bits signed.
  - A[i] = round(atan(2^-i) · 2^ZW / 2π), a constant table. A[0] = 2^(ZW-3).
  - Quadrant flags pipe alongside the data.
- Stage Q (unfold and output), with θ = final z clamped to the range 0..2^(ZW-2):
  - Quadrant 1 (!sx,!sy): θ
  - Quadrant 2 (sx,!sy): 2^(ZW-1) - θ
  - Quadrant 3 (sx,sy): 2^(ZW-1) + θ
  - Quadrant 4 (!sx,sy): 2^ZW - θ, taken mod 2^ZW so that an exact 0 maps to 0.
  - dout_mag is the final x, truncated to DW+1+DW_DOT bits.
- x = y = 0 yields dout_mag = 0 and dout_ang = 0.
- The pipeline advances every cycle and has no stall.
- dout_mag and dout_ang are forced to 0 on any cycle where dout_hsync = 0.

## Timing
- Latency: LAT = T_IR_NUM + 2 cycles. Add 1 when gain compensation is enabled.
- Throughput: one sample per clock.
- Sync alignment: dout_vsync and dout_hsync are exactly LAT-cycle shift registers of their inputs.
- Reset value: every output and every pipeline register resets to 0.
- Reset mid-frame: all in-flight samples and syncs are discarded. After release, the outputs stay 0 until new valid data has traversed the full LAT stages.
- Back-to-back hsync pulses and single-cycle hsync pulses must each produce one output per input cycle, with no merging.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - One extra register stage after Q multiplies the magnitude by K ≈ 0.607253.
  - K is implemented as a shift-add: (x>>1)+(x>>3)-(x>>6)-(x>>9)-(x>>12)+(x>>14), truncated.
  - The angle path and sync path get one matching extra delay stage.
- CORDIC_GAIN_COMP_EN undefined:
  - dout_mag carries the raw CORDIC gain of ≈1.64676.
  - LAT = T_IR_NUM + 2.

## Test plan
All scenarios use default parameters. Without the macro LAT = 17; with it LAT = 18.
- Q1 case: x=112, y=16, single-cycle hsync -> exactly one dout_hsync pulse, LAT cycles later.
  - dout_ang = 23681 ±2.
  - dout_mag = 2981 ±3 uncompensated, 1810 ±3 compensated.
- Q2 case: x=-112, y=16 -> dout_ang = 500607 ±2, same magnitude as the Q1 case.
- Negative y-axis: x=0, y=-100 -> dout_ang = 786432 ±2; dout_mag = 2635 ±3 uncompensated, 1600 ±3 compensated.
- Saturation: x=-32768, y=0 -> saturates, dout_ang = 524288 ±2; magnitude is that of 32767.
- Sync integrity:
  - Drive vsync high, then 5 consecutive hsync cycles with distinct samples. Outputs must be 5 consecutive results in order, and the syncs must be delayed exactly LAT cycles.
  - Outside hsync, dout_mag and dout_ang must read 0.
- Mid-stream reset: assert rst_n=0 while 3 samples are in flight -> all outputs become 0 immediately and asynchronously, and no stale sample emerges after release.
